// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS32 memory stage: memory-op codes, reset/zero
// constants, FSM state encoding and small op-classification helpers.
package mem_stage_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'd0;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Codes above OP_SW are undefined and behave exactly like OP_NONE.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op != OP_NONE) && (op <= OP_SW);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = addr_lo[0];
            OP_LW, OP_SW:         bad = (addr_lo != 2'b00);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte enables and replicated store data on the
// way out, lane selection plus sign/zero extension of load data on the way in.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Byte offset 0 is the most significant lane.
    always_comb begin
        byte_sel  = 4'b1000 >> addr_lo;
        half_sel  = addr_lo[1] ? 4'b0011 : 4'b1100;
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        case (addr_lo)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
    end

    always_comb begin
        sel        = 4'b0000;
        wdata_lane = ZeroWord;
        load_data  = ZeroWord;
        case (op)
            OP_LB: begin
                sel       = byte_sel;
                load_data = {{24{byte_lane[7]}}, byte_lane};
            end
            OP_LBU: begin
                sel       = byte_sel;
                load_data = {24'b0, byte_lane};
            end
            OP_LH: begin
                sel       = half_sel;
                load_data = {{16{half_lane[15]}}, half_lane};
            end
            OP_LHU: begin
                sel       = half_sel;
                load_data = {16'b0, half_lane};
            end
            OP_LW: begin
                sel       = 4'b1111;
                load_data = rdata;
            end
            OP_SB: begin
                sel        = byte_sel;
                wdata_lane = {4{wdata[7:0]}};
            end
            OP_SH: begin
                sel        = half_sel;
                wdata_lane = {2{wdata[15:0]}};
            end
            OP_SW: begin
                sel        = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                sel        = 4'b0000;
                wdata_lane = ZeroWord;
                load_data  = ZeroWord;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory pipeline stage: registered pass-through of ALU results and
// req/ack data-memory accesses with alignment checks, bus timeout and stalling.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [3:0]            mem_op_in,
    input  logic [ADDR_W-1:0]     mem_addr_in,
    input  logic [31:0]           mem_wdata_in,
    input  logic [REG_ADDR_W-1:0] dest_addr_in,
    input  logic                  wreg_in,
    input  logic [31:0]           dest_data_in,
    output logic                  stall_req,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [3:0]            dmem_sel,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] dest_addr_out,
    output logic                  wreg_out,
    output logic [31:0]           dest_data_out,
    output logic                  align_err,
    output logic                  bus_err,
    output logic [ADDR_W-1:0]     badvaddr
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic                  state;
    logic [3:0]            op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  wreg_q;
    logic [CNT_W-1:0]      cnt;

    logic [3:0]  lane_op;
    logic [1:0]  lane_addr;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        start_ok;
    logic        start_bad;
    logic        timed_out;

    // The aligner serves the incoming op in IDLE and the latched op in BUSY.
    assign lane_op   = (state == ST_BUSY) ? op_q : mem_op_in;
    assign lane_addr = (state == ST_BUSY) ? addr_q[1:0] : mem_addr_in[1:0];

    assign start_ok  = ex_valid && is_mem_op(mem_op_in) && !is_misaligned(mem_op_in, mem_addr_in[1:0]);
    assign start_bad = ex_valid && is_mem_op(mem_op_in) && is_misaligned(mem_op_in, mem_addr_in[1:0]);
    assign timed_out = (cnt == CNT_LAST);

    mem_lane_align u_lane_align (
        .op         (lane_op),
        .addr_lo    (lane_addr),
        .wdata      (mem_wdata_in),
        .rdata      (dmem_rdata),
        .sel        (lane_sel),
        .wdata_lane (lane_wdata),
        .load_data  (load_data)
    );

    // Stall is released in the ack cycle and in the abort cycle so EX advances there.
    always_comb begin
        stall_req = 1'b0;
        if (state == ST_IDLE) begin
            stall_req = start_ok;
        end else begin
            stall_req = !dmem_ack && !timed_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state         <= ST_IDLE;
            op_q          <= OP_NONE;
            addr_q        <= '0;
            dest_q        <= REG_ADDR_W'(NOPRegAddr);
            wreg_q        <= 1'b0;
            cnt           <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_sel      <= 4'b0000;
            dmem_wdata    <= ZeroWord;
            wb_valid      <= 1'b0;
            wreg_out      <= 1'b0;
            dest_addr_out <= REG_ADDR_W'(NOPRegAddr);
            dest_data_out <= ZeroWord;
            align_err     <= 1'b0;
            bus_err       <= 1'b0;
            badvaddr      <= '0;
        end else begin
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (start_ok) begin
                    state      <= ST_BUSY;
                    op_q       <= mem_op_in;
                    addr_q     <= mem_addr_in;
                    dest_q     <= dest_addr_in;
                    wreg_q     <= wreg_in;
                    dmem_req   <= 1'b1;
                    dmem_we    <= is_store_op(mem_op_in);
                    dmem_addr  <= {mem_addr_in[ADDR_W-1:2], 2'b00};
                    dmem_sel   <= lane_sel;
                    dmem_wdata <= lane_wdata;
                    wb_valid   <= 1'b0;
                    wreg_out   <= 1'b0;
                end else if (start_bad) begin
                    wb_valid      <= 1'b1;
                    wreg_out      <= 1'b0;
                    align_err     <= 1'b1;
                    badvaddr      <= mem_addr_in;
                    dest_addr_out <= dest_addr_in;
                    dest_data_out <= dest_data_in;
                end else if (ex_valid) begin
                    wb_valid      <= 1'b1;
                    wreg_out      <= wreg_in;
                    dest_addr_out <= dest_addr_in;
                    dest_data_out <= dest_data_in;
                end else begin
                    wb_valid <= 1'b0;
                    wreg_out <= 1'b0;
                end
            end else begin
                // An ack in the expiry cycle still completes the access normally.
                if (dmem_ack) begin
                    state         <= ST_IDLE;
                    dmem_req      <= 1'b0;
                    wb_valid      <= 1'b1;
                    wreg_out      <= wreg_q && !is_store_op(op_q);
                    dest_addr_out <= dest_q;
                    dest_data_out <= load_data;
                end else if (timed_out) begin
                    state         <= ST_IDLE;
                    dmem_req      <= 1'b0;
                    wb_valid      <= 1'b1;
                    wreg_out      <= 1'b0;
                    bus_err       <= 1'b1;
                    badvaddr      <= addr_q;
                    dest_addr_out <= dest_q;
                end else begin
                    cnt      <= cnt + 1'b1;
                    wb_valid <= 1'b0;
                    wreg_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a byte-lane reference
// model of big-endian MIPS loads/stores, alignment, timeout and reset behaviour.
module tb_mem_stage;

    localparam int TO = 4;

    localparam logic [3:0] NONE = 4'd0;
    localparam logic [3:0] LB   = 4'd1;
    localparam logic [3:0] LBU  = 4'd2;
    localparam logic [3:0] LH   = 4'd3;
    localparam logic [3:0] LHU  = 4'd4;
    localparam logic [3:0] LW   = 4'd5;
    localparam logic [3:0] SB   = 4'd6;
    localparam logic [3:0] SH   = 4'd7;
    localparam logic [3:0] SW   = 4'd8;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  mem_op_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic [4:0]  dest_addr_in;
    logic        wreg_in;
    logic [31:0] dest_data_in;
    logic        stall_req;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_sel;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [4:0]  dest_addr_out;
    logic        wreg_out;
    logic [31:0] dest_data_out;
    logic        align_err;
    logic        bus_err;
    logic [31:0] badvaddr;

    int vectors     = 0;
    int miscompares = 0;

    mem_stage #(
        .ADDR_W     (32),
        .REG_ADDR_W (5),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .mem_op_in     (mem_op_in),
        .mem_addr_in   (mem_addr_in),
        .mem_wdata_in  (mem_wdata_in),
        .dest_addr_in  (dest_addr_in),
        .wreg_in       (wreg_in),
        .dest_data_in  (dest_data_in),
        .stall_req     (stall_req),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_sel      (dmem_sel),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .wb_valid      (wb_valid),
        .dest_addr_out (dest_addr_out),
        .wreg_out      (wreg_out),
        .dest_data_out (dest_data_out),
        .align_err     (align_err),
        .bus_err       (bus_err),
        .badvaddr      (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an access of w bytes covers byte offsets start..start+w-1,
    // with offset 0 being the most significant byte of the bus word.
    function automatic int width_of(input logic [3:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic logic model_misaligned(input logic [3:0] op, input logic [31:0] addr);
        int w;
        w = width_of(op);
        return (w > 1) && ((int'(addr[1:0]) % w) != 0);
    endfunction

    function automatic logic [3:0] model_sel(input logic [3:0] op, input logic [31:0] addr);
        int w;
        int start;
        logic [3:0] s;
        w = width_of(op);
        start = int'(addr[1:0]);
        start = start - (start % w);
        s = 4'b0000;
        for (int b = start; b < start + w; b++) s[3 - b] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] wdata);
        int w;
        logic [63:0] mask;
        logic [63:0] chunk;
        logic [63:0] r;
        w = width_of(op);
        mask = (64'd1 << (8 * w)) - 64'd1;
        chunk = {32'b0, wdata} & mask;
        r = 64'd0;
        for (int i = 0; i < 4; i += w) r = r | (chunk << (8 * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int w;
        int start;
        logic [63:0] mask;
        logic [63:0] v;
        w = width_of(op);
        start = int'(addr[1:0]);
        start = start - (start % w);
        mask = (64'd1 << (8 * w)) - 64'd1;
        v = ({32'b0, rdata} >> (8 * (4 - start - w))) & mask;
        if ((op == LB || op == LH) && v[8 * w - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic drive_ex(input logic v, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] dest, input logic w,
                            input logic [31:0] data);
        ex_valid     = v;
        mem_op_in    = op;
        mem_addr_in  = addr;
        mem_wdata_in = wdata;
        dest_addr_in = dest;
        wreg_in      = w;
        dest_data_in = data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        vectors++;
        if ({dmem_req, dmem_we, dmem_sel, wb_valid, wreg_out, align_err, bus_err, stall_req} !== 11'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, expected 0",
                     {dmem_req, dmem_we, dmem_sel, wb_valid, wreg_out, align_err, bus_err, stall_req});
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({dmem_addr, dmem_wdata, dest_data_out, badvaddr, dest_addr_out} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_words: got addr %h wdata %h data %h badv %h dest %h, expected all 0",
                     dmem_addr, dmem_wdata, dest_data_out, badvaddr, dest_addr_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_none;
        logic        v;
        logic        w;
        logic [3:0]  op;
        logic [4:0]  d;
        logic [31:0] data;
        drive_ex(1'b1, NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234_5678);
        for (int i = 0; i < 17; i++) begin
            #1;
            vectors++;
            if (stall_req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL none_stall: got %b, expected 0", stall_req);
            end
            v = ex_valid; w = wreg_in; d = dest_addr_in; data = dest_data_in;
            @(posedge clk);
            #1;
            vectors++;
            if (wb_valid !== v || wreg_out !== (v && w) || dmem_req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL none_valid: got wb %b wreg %b req %b, expected wb %b wreg %b req 0",
                         wb_valid, wreg_out, dmem_req, v, v && w);
            end
            if (v) begin
                vectors++;
                if (dest_addr_out !== d || dest_data_out !== data) begin
                    miscompares++;
                    $display("[TB] FAIL none_data: got dest %0d data %h, expected dest %0d data %h",
                             dest_addr_out, dest_data_out, d, data);
                end
            end
            op = (i % 2 == 0) ? NONE : 4'($urandom_range(9, 15));
            drive_ex(($urandom_range(0, 3) != 0), op, $urandom, $urandom, 5'($urandom),
                     1'($urandom), $urandom);
            dmem_ack = 1'($urandom);
        end
        dmem_ack = 1'b0;
        drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int delay, input logic [4:0] dest,
                               input logic w);
        int stalls;
        logic st;
        st = (op == SB || op == SH || op == SW);
        stalls = 0;
        drive_ex(1'b1, op, addr, wdata, dest, w, $urandom);
        #1;
        if (stall_req === 1'b1) stalls++;
        vectors++;
        if (dmem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mem_req_early: got %b, expected 0", dmem_req);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== (addr & 32'hFFFF_FFFC) ||
            dmem_sel !== model_sel(op, addr) || wb_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mem_bus op%0d: got req %b we %b addr %h sel %b wb %b, expected 1 %b %h %b 0",
                     op, dmem_req, dmem_we, dmem_addr, dmem_sel, wb_valid, st,
                     addr & 32'hFFFF_FFFC, model_sel(op, addr));
        end
        if (st) begin
            vectors++;
            if (dmem_wdata !== model_wdata(op, wdata)) begin
                miscompares++;
                $display("[TB] FAIL mem_wdata op%0d: got %h, expected %h", op, dmem_wdata, model_wdata(op, wdata));
            end
        end
        drive_ex(1'b1, 4'($urandom), $urandom, $urandom, 5'($urandom), 1'b1, $urandom);
        for (int i = 0; i < delay; i++) begin
            #1;
            if (stall_req === 1'b1) stalls++;
            vectors++;
            if (dmem_req !== 1'b1 || dmem_addr !== (addr & 32'hFFFF_FFFC) || dmem_sel !== model_sel(op, addr)) begin
                miscompares++;
                $display("[TB] FAIL mem_hold: got req %b addr %h sel %b, expected 1 %h %b",
                         dmem_req, dmem_addr, dmem_sel, addr & 32'hFFFF_FFFC, model_sel(op, addr));
            end
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        #1;
        if (stall_req === 1'b1) stalls++;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        vectors++;
        if (stalls !== delay + 1) begin
            miscompares++;
            $display("[TB] FAIL mem_stall_cycles: got %0d, expected %0d", stalls, delay + 1);
        end
        vectors++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wreg_out !== (w && !st) || dest_addr_out !== dest ||
            align_err !== 1'b0 || bus_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mem_done op%0d: got req %b wb %b wreg %b dest %0d aerr %b berr %b, expected 0 1 %b %0d 0 0",
                     op, dmem_req, wb_valid, wreg_out, dest_addr_out, align_err, bus_err, w && !st, dest);
        end
        if (!st) begin
            vectors++;
            if (dest_data_out !== model_load(op, addr, rdata)) begin
                miscompares++;
                $display("[TB] FAIL mem_load op%0d: got %h, expected %h", op, dest_data_out, model_load(op, addr, rdata));
            end
        end
        drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_load_directed;
        test_mem_op(LB, 32'h0000_1001, 32'h0, 32'h1180_2233, 1, 5'd4, 1'b1);
        vectors++;
        if (dest_data_out !== 32'hFFFF_FF80) begin
            miscompares++;
            $display("[TB] FAIL lb_sign: got %h, expected ffffff80", dest_data_out);
        end
        test_mem_op(LBU, 32'h0000_1001, 32'h0, 32'h1180_2233, 1, 5'd4, 1'b1);
        vectors++;
        if (dest_data_out !== 32'h0000_0080) begin
            miscompares++;
            $display("[TB] FAIL lbu_zero: got %h, expected 00000080", dest_data_out);
        end
    endtask

    task automatic test_store_directed;
        test_mem_op(SH, 32'h0000_2002, 32'h0000_BEEF, $urandom, 3, 5'd6, 1'b1);
        vectors++;
        if (wreg_out !== 1'b0 || wb_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sh_wb: got wreg %b wb %b, expected 0 1", wreg_out, wb_valid);
        end
    endtask

    task automatic test_misaligned;
        logic [3:0]  mis_ops [5];
        logic [3:0]  op;
        logic [31:0] addr;
        mis_ops = '{LH, LHU, SH, LW, SW};
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                op = LW;
                addr = 32'h0000_3002;
            end else begin
                op = mis_ops[$urandom_range(0, 4)];
                addr = $urandom;
                if (width_of(op) == 2) addr[0] = 1'b1;
                else addr[1:0] = 2'($urandom_range(1, 3));
            end
            drive_ex(1'b1, op, addr, $urandom, 5'($urandom), 1'b1, $urandom);
            #1;
            vectors++;
            if (stall_req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mis_stall: got %b, expected 0", stall_req);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wreg_out !== 1'b0 ||
                align_err !== model_misaligned(op, addr) || badvaddr !== addr || bus_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mis_report op%0d: got req %b wb %b wreg %b aerr %b badv %h, expected 0 1 0 1 %h",
                         op, dmem_req, wb_valid, wreg_out, align_err, badvaddr, addr);
            end
        end
        drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        vectors++;
        if (align_err !== 1'b0 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mis_pulse: got aerr %b wb %b, expected 0 0", align_err, wb_valid);
        end
    endtask

    task automatic test_timeout;
        int busy;
        logic [31:0] data;
        drive_ex(1'b1, SW, 32'h0000_0500, 32'hCAFE_F00D, 5'd9, 1'b1, 32'h0);
        #1;
        vectors++;
        if (stall_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_stall0: got %b, expected 1", stall_req);
        end
        @(posedge clk);
        #1;
        drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        busy = 0;
        while (dmem_req === 1'b1 && busy < 3 * TO) begin
            #1;
            vectors++;
            if (stall_req !== (busy + 1 < TO)) begin
                miscompares++;
                $display("[TB] FAIL to_stall busy%0d: got %b, expected %b", busy + 1, stall_req, busy + 1 < TO);
            end
            busy++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (busy !== TO) begin
            miscompares++;
            $display("[TB] FAIL to_cycles: got %0d, expected %0d", busy, TO);
        end
        vectors++;
        if (wb_valid !== 1'b1 || bus_err !== 1'b1 || wreg_out !== 1'b0 || badvaddr !== 32'h0000_0500 ||
            align_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL to_report: got wb %b berr %b wreg %b badv %h aerr %b, expected 1 1 0 00000500 0",
                     wb_valid, bus_err, wreg_out, badvaddr, align_err);
        end
        for (int i = 0; i < 3; i++) begin
            data = $urandom;
            drive_ex(1'b1, NONE, $urandom, $urandom, 5'(i + 1), 1'b1, data);
            #1;
            vectors++;
            if (stall_req !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL to_next_stall: got %b, expected 0", stall_req);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (wb_valid !== 1'b1 || bus_err !== 1'b0 || wreg_out !== 1'b1 ||
                dest_addr_out !== 5'(i + 1) || dest_data_out !== data) begin
                miscompares++;
                $display("[TB] FAIL to_next_none: got wb %b berr %b wreg %b dest %0d data %h, expected 1 0 1 %0d %h",
                         wb_valid, bus_err, wreg_out, dest_addr_out, dest_data_out, i + 1, data);
            end
        end
        drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_random_mem;
        logic [3:0]  op;
        logic [31:0] addr;
        int          w;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 8));
            w = width_of(op);
            addr = $urandom & ~32'(w - 1);
            test_mem_op(op, addr, $urandom, $urandom, $urandom_range(0, TO - 1), 5'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_busy;
        drive_ex(1'b1, LW, 32'h0000_0080, 32'h0, 5'd3, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rb_req_before: got %b, expected 1", dmem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (dmem_req !== 1'b0 || stall_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rb_async: got req %b stall %b, expected 0 0", dmem_req, stall_req);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (wb_valid !== 1'b0 || wreg_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rb_no_wb: got wb %b wreg %b, expected 0 0", wb_valid, wreg_out);
        end
        test_mem_op(LW, 32'h0000_0040, 32'h0, $urandom, 0, 5'd7, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive_ex(1'b0, NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        test_reset;
        test_none;
        test_load_directed;
        test_store_directed;
        test_misaligned;
        test_timeout;
        test_random_mem;
        test_reset_busy;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised MIPS32 memory pipeline stage sitting between the execute stage and write-back. It forwards ALU results and performs byte, halfword and word loads and stores over a request/acknowledge data-memory bus. It handles big-endian lane steering, sign/zero extension, misalignment detection, a bus timeout and pipeline stall generation. Its outputs are registered, so the stage is a true pipeline register.

## Interface
Parameters:
- `ADDR_W`, 32: data-memory byte-address width.
- `REG_ADDR_W`, 5: destination register index width.
- `TIMEOUT`, 255: maximum cycles to wait for `dmem_ack` before aborting (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Asynchronous and active-high (`rst == 1` resets).
- `ex_valid` in 1: execute-stage result valid this cycle.
- `mem_op_in` in 4: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; other codes are treated as NONE.
- `mem_addr_in` in ADDR_W: effective byte address.
- `mem_wdata_in` in 32: store data, right-aligned.
- `dest_addr_in` in REG_ADDR_W, `wreg_in` in 1, `dest_data_in` in 32: write-back request from EX.
- `stall_req` out 1: upstream must hold its inputs; combinational.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out ADDR_W (bits [1:0]=0), `dmem_sel` out 4, `dmem_wdata` out 32: bus request, all registered.
- `dmem_rdata` in 32, `dmem_ack` in 1: bus response, valid when `dmem_ack`=1.
- `wb_valid` out 1, `dest_addr_out` out REG_ADDR_W, `wreg_out` out 1, `dest_data_out` out 32: to write-back.
- `align_err` out 1, `bus_err` out 1, `badvaddr` out ADDR_W: exception report, valid with `wb_valid`.

## Operation
- FSM states are IDLE and BUSY.
- **IDLE, NONE op with `ex_valid`:**
  - Registers the inputs to the outputs next edge.
  - `wb_valid`=1 and `wreg_out`=`wreg_in`.
- **IDLE, memory op with `ex_valid`, aligned:**
  - `stall_req`=1.
  - At the edge, latches the op and dest info, drives the bus registers, and goes to BUSY.
- **Alignment rules:**
  - LH/LHU/SH are misaligned if addr[0]=1.
  - LW/SW are misaligned if addr[1:0]≠0.
- **IDLE, misaligned op:**
  - No bus access and `stall_req`=0.
  - Next edge: `wb_valid`=1, `wreg_out`=0, `align_err`=1, `badvaddr`=address.
- **BUSY:**
  - Bus outputs are held stable.
  - `stall_req`=~`dmem_ack`.
  - The timeout counter increments each cycle.
- **BUSY, `dmem_ack`=1:**
  - Next edge: `dmem_req`=0, state IDLE, `wb_valid`=1.
  - Loads: `wreg_out`=latched wreg, `dest_data_out`=extended data.
  - Stores: `wreg_out`=0.
- **BUSY, no ack after `TIMEOUT` cycles:**
  - Drop `dmem_req`, go to IDLE.
  - Next edge: `wb_valid`=1, `bus_err`=1, `wreg_out`=0, `badvaddr` set.
  - `stall_req` is low in the abort cycle.
- **Lane steering (big-endian):**
  - Byte offset 0 maps to bits[31:24]; `dmem_sel`[3] covers bits[31:24].
  - SB: `dmem_sel`=1000>>addr[1:0]; data byte replicated in all lanes.
  - SH: `dmem_sel`=1100 (addr[1]=0) or 0011; halfword replicated.
  - SW and all loads: SW uses `dmem_sel`=1111. Loads assert `dmem_we`=0, use the same byte-enable pattern as the matching store width, and select the lane from addr[1:0].
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
- **When `ex_valid`=0 in IDLE:** next edge gives `wb_valid`=0 and `wreg_out`=0.
- **In BUSY:** the EX inputs are ignored.
- **Reset values:**
  - `dmem_req`=0, `dmem_we`=0, `dmem_sel`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - `wb_valid`=0, `wreg_out`=0, `dest_addr_out`=0, `dest_data_out`=0.
  - `align_err`=0, `bus_err`=0, `badvaddr`=0, `stall_req`=0.
  - State IDLE, counter 0.

## Timing
- Non-memory op: 1-cycle latency and full throughput.
- Memory op with ack in the first BUSY cycle: presented in cycle 0, `dmem_req`=1 in cycle 1, ack in cycle 1, `wb_valid` in cycle 2. Two cycles occupied.
- `stall_req`=1 in cycle 0 and in every BUSY cycle without ack; it is 0 in the ack cycle, so EX advances at that edge.
- `dmem_ack` is ignored outside BUSY.
- Ack arriving in the same cycle the timeout expires counts as success.
- Asynchronous `rst` mid-BUSY: `dmem_req` drops immediately without waiting for the clock, and no write-back is produced for that op.
- Error flags are single-cycle pulses aligned with `wb_valid`.

## Structure
- Shared package (`defines`) holds:
  - the mem-op encodings;
  - `RstEnable`, `ZeroWord`, `NOPRegAddr`;
  - the FSM state encoding.
- One natural sub-module, `mem_lane_align`: purely combinational.
  - Store direction: produces `dmem_sel`/`dmem_wdata` from op, addr[1:0] and wdata.
  - Load direction: produces extended load data from op, addr[1:0] and rdata.
- The top level holds the FSM, timeout counter and output registers.

## Test plan
- NONE op, `wreg_in`=1, dest 5, data 0x1234_5678 → next cycle `wb_valid`=1, `wreg_out`=1, dest 5, data 0x1234_5678, `stall_req`=0 throughout.
- LB at 0x1001, ack one cycle after request, rdata 0x11_80_22_33 → `dmem_sel`=0100, `dmem_addr`=0x1000, `dest_data_out`=0xFFFF_FF80. LBU of the same access gives 0x0000_0080.
- SH at 0x2002 with wdata 0x0000_BEEF, ack after 3 BUSY cycles → `dmem_we`=1, `dmem_sel`=0011, `dmem_wdata`=0xBEEF_BEEF, `stall_req` high for 4 cycles, `wreg_out`=0.
- LW at 0x3002 → no `dmem_req`, next cycle `align_err`=1, `badvaddr`=0x3002, `wreg_out`=0.
- With `TIMEOUT`=4, SW and no ack → `dmem_req` drops after 4 BUSY cycles, then `bus_err`=1 pulse, then back-to-back NONE ops proceed.
- Assert `rst` during BUSY (between clock edges) → `dmem_req`=0 immediately; after release, a LW at 0x40 succeeds normally.
